tick_sched: RTL and testbench

//   Run/pause/single-step controller around a programmable divide-by-N counter.

---
 rtl/tick_sched.sv | 66 ++++++
 tb/tb_tick_sched.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/tick_sched.sv
// tick_sched: run/pause/single-step controller around a rate-selectable divide-by-N tick generator.
module tick_sched #(
  parameter int DIV0 = 5000000,
  parameter int DIV1 = 2500000,
  parameter int DIV2 = 1000000,
  parameter int DIV3 = 100000,
  parameter int CW   = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  input  logic [1:0] rate_sel,
  output logic       tick,
  output logic       signal,
  output logic       busy,
  output logic [1:0] state
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, STEP = 2'd3} state_t;
  state_t st, nxt;
  logic [CW-1:0] cnt, term;
  logic [1:0] act_sel;
  logic counting, wrap;
  always_comb begin
    term = act_sel == 2'd0 ? CW'(DIV0 - 1) :
           act_sel == 2'd1 ? CW'(DIV1 - 1) :
           act_sel == 2'd2 ? CW'(DIV2 - 1) : CW'(DIV3 - 1);
    counting = st == RUN || st == STEP;
    wrap = counting && cnt == term;
    nxt = st;
    case (st)
      IDLE:    nxt = stop ? IDLE : start ? RUN : step ? STEP : IDLE;
      PAUSE:   nxt = stop ? IDLE : start ? RUN : step ? STEP : PAUSE;
      RUN:     nxt = stop ? PAUSE : RUN;
      default: nxt = stop ? PAUSE : start ? RUN : wrap ? PAUSE : STEP;
    endcase
  end
  // act_sel only reloads at a period boundary or while idle, so a period is never truncated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= IDLE;
      cnt     <= '0;
      act_sel <= 2'd0;
      tick    <= 1'b0;
      signal  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      st   <= nxt;
      busy <= nxt == RUN || nxt == STEP;
      tick <= wrap;
      if (st == IDLE || (st == PAUSE && stop)) begin
        cnt     <= '0;
        act_sel <= rate_sel;
        signal  <= st == IDLE ? signal : 1'b0;
      end else if (wrap) begin
        cnt     <= '0;
        act_sel <= rate_sel;
        signal  <= ~signal;
      end else if (counting && !stop) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
  assign state = st;
endmodule

// File: tb/tb_tick_sched.sv
// tb_tick_sched: directed scenarios plus random pulses, checked each cycle against a period-level model.
module tb_tick_sched;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, step = 1'b0;
  logic [1:0] rate_sel = 2'd0;
  logic tick, signal, busy;
  logic [1:0] state;
  logic [1:0] rs = 2'd0;
  int checks = 0, errors = 0;
  int m_mode, m_done, m_len, m_sig, m_tick;
  int n;

  tick_sched #(.DIV0(4), .DIV1(6), .DIV2(8), .DIV3(10), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step),
    .rate_sel(rate_sel), .tick(tick), .signal(signal), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  function automatic int len_of(input logic [1:0] r);
    return r == 2'd0 ? 4 : r == 2'd1 ? 6 : r == 2'd2 ? 8 : 10;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_done = 0; m_len = 4; m_sig = 0; m_tick = 0;
  endtask

  // mode: 0 idle, 1 run, 2 pause, 3 step; m_done = cycles elapsed in the current period
  task automatic model(input bit a, input bit b, input bit c, input logic [1:0] r);
    m_tick = 0;
    if (m_mode == 0) begin
      m_done = 0; m_len = len_of(r);
      if (!b) m_mode = a ? 1 : c ? 3 : 0;
    end else if (m_mode == 2) begin
      if (b) begin m_mode = 0; m_done = 0; m_sig = 0; m_len = len_of(r); end
      else if (a) m_mode = 1;
      else if (c) m_mode = 3;
    end else begin
      if (m_done + 1 == m_len) begin
        m_tick = 1; m_sig = 1 - m_sig; m_done = 0; m_len = len_of(r);
        m_mode = b ? 2 : (m_mode == 1 || a) ? 1 : 2;
      end else if (b) m_mode = 2;
      else begin
        m_done++;
        if (a) m_mode = 1;
      end
    end
  endtask

  task automatic cyc(input bit a, input bit b, input bit c);
    start = a; stop = b; step = c; rate_sel = rs;
    @(posedge clk);
    model(a, b, c, rs);
    #1;
    chk("tick", tick, m_tick);
    chk("signal", signal, m_sig);
    chk("busy", busy, (m_mode == 1 || m_mode == 3) ? 1 : 0);
    chk("state", state, m_mode);
    start = 0; stop = 0; step = 0;
  endtask

  task automatic wait_tick(output int cnt);
    cnt = -1;
    for (int i = 1; i <= 40; i++) begin
      cyc(0, 0, 0);
      if (tick === 1'b1) begin cnt = i; break; end
    end
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset_tick", tick, 0);
    chk("reset_signal", signal, 0);
    chk("reset_busy", busy, 0);
    chk("reset_state", state, 0);
    @(negedge clk) rst_n = 1'b1;
    // 1: free run at rate 0
    rs = 2'd0;
    cyc(1, 0, 0);
    wait_tick(n); chk("t1_first_tick", n, 4);
    wait_tick(n); chk("t1_period", n, 4);
    chk("t1_signal", signal, 0);
    // 3: rate 1, stop at cnt=3, resume completes remaining 3 cycles
    cyc(0, 1, 0); cyc(0, 1, 0);
    rs = 2'd1;
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    cyc(0, 1, 0);
    repeat (4) cyc(0, 0, 0);
    chk("t3_paused", state, 2);
    cyc(1, 0, 0);
    wait_tick(n); chk("t3_resume", n, 3);
    // 5: stop on the terminal-count edge still ticks
    repeat (5) cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("t5_tick", tick, 1);
    chk("t5_state", state, 2);
    // 4: single steps from cnt=0
    cyc(0, 0, 1);
    wait_tick(n); chk("t4_step1", n, 6);
    chk("t4_state1", state, 2);
    cyc(0, 0, 1);
    wait_tick(n); chk("t4_step2", n, 6);
    chk("t4_state2", state, 2);
    cyc(0, 1, 0);
    chk("t5_idle", state, 0);
    chk("t5_sig_clr", signal, 0);
    // 2: rate change mid-period applies from the next period
    rs = 2'd0;
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    rs = 2'd3;
    wait_tick(n); chk("t2_old_rate", n, 3);
    wait_tick(n); chk("t2_new_rate", n, 10);
    // 6: start+stop together from idle, then async reset mid-run
    cyc(0, 1, 0); cyc(0, 1, 0);
    cyc(1, 1, 0);
    chk("t6_stay_idle", state, 0);
    cyc(1, 0, 0);
    repeat (12) cyc(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_tick", tick, 0);
    chk("t6_rst_signal", signal, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_state", state, 0);
    @(negedge clk) rst_n = 1'b1;
    // random pulses and rate changes against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        chk("rnd_rst_state", state, 0);
        @(negedge clk) rst_n = 1'b1;
      end
      cyc($urandom_range(0, 24) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
